// File: rtl/debounce_edge_pkg.sv
// rtl/debounce_edge_pkg.sv - shared state encoding for the debounce_edge block
package debounce_edge_pkg;

  localparam logic [1:0] ST_IDLE_LO = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_IDLE_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  typedef enum logic [1:0] {
    IDLE_LO = ST_IDLE_LO,
    WAIT_HI = ST_WAIT_HI,
    IDLE_HI = ST_IDLE_HI,
    WAIT_LO = ST_WAIT_LO
  } state_t;

endpackage

// File: rtl/sync_ff_chain.sv
// rtl/sync_ff_chain.sv - reset-to-0 synchronizer shift chain for async inputs
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the raw input through STAGES flops; bit 0 is the metastability catcher
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - synchronize, debounce and edge-detect a noisy async input
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int STABLE_CNT  = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  // reject builds where the chain is too short or the count cannot fit the counter
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_edge: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CNT < 1 || (64'(STABLE_CNT) >= (64'd1 << CNT_W))) begin : g_bad_cnt
    $error("debounce_edge: STABLE_CNT must be in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (din),
    .q       (s)
  );

  // qualify candidate transitions on s; q and the pulses change only on the qualifying edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE_LO;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LO: begin
          if (s) begin
            if (STABLE_CNT == 1) begin
              state <= IDLE_HI;
              q     <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= WAIT_HI;
              cnt   <= CNT_W'(1);
            end
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state <= IDLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HI;
            cnt   <= '0;
            q     <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HI: begin
          if (!s) begin
            if (STABLE_CNT == 1) begin
              state <= IDLE_LO;
              q     <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= WAIT_LO;
              cnt   <= CNT_W'(1);
            end
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= IDLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LO;
            cnt   <= '0;
            q     <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == WAIT_HI) || (state == WAIT_LO);

endmodule

// File: tb/tb_debounce_edge.sv
// tb/tb_debounce_edge.sv - table-driven self-checking bench for debounce_edge
module tb_debounce_edge;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic din = 1'b0;
  logic q, rise, fall, busy;
  logic din1 = 1'b0;
  logic q1, rise1, fall1, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debounce_edge #(.SYNC_STAGES(2), .CNT_W(4), .STABLE_CNT(4)) dut (
    .clk(clk), .reset_n(reset_n), .din(din),
    .q(q), .rise(rise), .fall(fall), .busy(busy)
  );

  debounce_edge #(.SYNC_STAGES(2), .CNT_W(4), .STABLE_CNT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .din(din1),
    .q(q1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  typedef struct packed {
    logic din;
    logic q;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t tbl [0:27];

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input int idx, input logic eq, input logic er,
                            input logic ef, input logic eb);
    check({tag, ".q"}, idx, q, eq);
    check({tag, ".rise"}, idx, rise, er);
    check({tag, ".fall"}, idx, fall, ef);
    check({tag, ".busy"}, idx, busy, eb);
    check({tag, ".no_overlap"}, idx, rise & fall, 1'b0);
  endtask

  function automatic vec_t mk(input logic d, input logic eq, input logic er, input logic ef,
                              input logic eb);
    vec_t v;
    v.din = d; v.q = eq; v.rise = er; v.fall = ef; v.busy = eb;
    return v;
  endfunction

  initial begin
    // bounce then qualified rise: highs x2, low, highs x3, low, then steady high (edges 0..13)
    tbl[0]  = mk(1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1);
    tbl[3]  = mk(1, 0, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 0, 1);
    tbl[8]  = mk(1, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 1);
    tbl[10] = mk(1, 0, 0, 0, 1);
    tbl[11] = mk(1, 0, 0, 0, 1);
    tbl[12] = mk(1, 1, 1, 0, 0);
    tbl[13] = mk(1, 1, 0, 0, 0);
    // falling transition from q=1 (edges 0..6)
    tbl[14] = mk(0, 1, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 0);
    tbl[16] = mk(0, 1, 0, 0, 1);
    tbl[17] = mk(0, 1, 0, 0, 1);
    tbl[18] = mk(0, 1, 0, 0, 1);
    tbl[19] = mk(0, 0, 0, 1, 0);
    tbl[20] = mk(0, 0, 0, 0, 0);
    // clean rising transition from q=0 (edges 0..6)
    tbl[21] = mk(1, 0, 0, 0, 0);
    tbl[22] = mk(1, 0, 0, 0, 0);
    tbl[23] = mk(1, 0, 0, 0, 1);
    tbl[24] = mk(1, 0, 0, 0, 1);
    tbl[25] = mk(1, 0, 0, 0, 1);
    tbl[26] = mk(1, 1, 1, 0, 0);
    tbl[27] = mk(1, 1, 0, 0, 0);

    // reset state
    reset_n = 1'b0;
    din = 1'b0;
    din1 = 1'b0;
    step();
    step();
    check_main("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // idle low for 20 cycles
    for (int i = 0; i < 20; i++) begin
      din = 1'b0;
      step();
      check_main("idle", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // table: bounce, fall, rise
    for (int i = 0; i < 28; i++) begin
      din = tbl[i].din;
      step();
      check_main("tbl", i, tbl[i].q, tbl[i].rise, tbl[i].fall, tbl[i].busy);
    end

    // async reset mid WAIT_HI: return low, then start a new rise and cut it at cnt=2
    din = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_main("pre_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    din = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pre_rst.busy_wait", 0, busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst.q", 0, q, 1'b0);
    check("async_rst.rise", 0, rise, 1'b0);
    check("async_rst.busy", 0, busy, 1'b0);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      check_main("post_rst", i, (i >= 5), (i == 5), 1'b0, (i >= 2 && i <= 4));
    end

    // STABLE_CNT=1 build: steady high, rise at edge 2
    din1 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("sc1.q_idle", 0, q1, 1'b0);
    din1 = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      step();
      check("sc1.q", i, q1, (i >= 2));
      check("sc1.rise", i, rise1, (i == 2));
      check("sc1.fall", i, fall1, 1'b0);
      check("sc1.busy", i, busy1, 1'b0);
    end
    // return low, then a single-cycle pulse
    din1 = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("sc1.q_low", 0, q1, 1'b0);
    din1 = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      step();
      din1 = 1'b0;
      check("sc1p.q", i, q1, (i == 2));
      check("sc1p.rise", i, rise1, (i == 2));
      check("sc1p.fall", i, fall1, (i == 3));
      check("sc1p.no_overlap", i, rise1 & fall1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
